// File: rtl/simple_bus_rr_arbiter_if.sv
// Bundle of per-master request ports and the shared slave-side bus seen by the arbiter.
// The master modport is the arbiter's view; slave is the environment (clients + slave) view.
interface simple_bus_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
);
  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*2-1:0]      m_mode;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_gnt;
  logic [NUM_MASTERS-1:0]        m_done;
  logic [NUM_MASTERS-1:0]        m_err;
  logic [DATA_W-1:0]             m_rdata;
  logic                          s_start;
  logic [ADDR_W-1:0]             s_addr;
  logic [1:0]                    s_mode;
  logic [DATA_W-1:0]             s_wdata;
  logic                          s_rdy;
  logic [DATA_W-1:0]             s_rdata;
  logic                          busy;

  modport master (
    input  m_req, m_addr, m_mode, m_wdata, s_rdy, s_rdata,
    output m_gnt, m_done, m_err, m_rdata, s_start, s_addr, s_mode, s_wdata, busy
  );

  modport slave (
    output m_req, m_addr, m_mode, m_wdata, s_rdy, s_rdata,
    input  m_gnt, m_done, m_err, m_rdata, s_start, s_addr, s_mode, s_wdata, busy
  );
endinterface

// File: rtl/simple_bus_rr_arbiter.sv
// Round-robin N-master front end for simple_bus: one slave transfer at a time,
// with completion/error returned to the granted master and an optional s_rdy timeout.
module simple_bus_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT     = 255
) (
  input logic                    clk,
  input logic                    rst,
  simple_bus_rr_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  logic [NUM_MASTERS-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_MASTERS-1:0][1:0]        mode_a;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] wdata_a;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = bus.m_addr[i*ADDR_W +: ADDR_W];
    assign mode_a[i]  = bus.m_mode[i*2 +: 2];
    assign wdata_a[i] = bus.m_wdata[i*DATA_W +: DATA_W];
  end

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       win_q, win_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [NUM_MASTERS-1:0] done_q, done_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   start_q, start_d;
  logic [ADDR_W-1:0]      saddr_q, saddr_d;
  logic [1:0]             smode_q, smode_d;
  logic [DATA_W-1:0]      swdata_q, swdata_d;
  logic                   busy_q, busy_d;

  logic             found;
  logic [PTR_W-1:0] win;
  int               idx;
  logic [CNT_W:0]   cnt_inc;
  logic [PTR_W-1:0] ptr_next;

  // First requester at or after the pointer, wrapping past the last master.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && bus.m_req[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign ptr_next = (win_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : win_q + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    start_d  = 1'b0;
    saddr_d  = saddr_q;
    smode_d  = smode_q;
    swdata_d = swdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d      = win;
          saddr_d    = addr_a[win];
          smode_d    = mode_a[win];
          swdata_d   = wdata_a[win];
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          start_d    = 1'b1;
          cnt_d      = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        // s_rdy is checked before the timeout so a coincident ready is never an error.
        if (bus.s_rdy) begin
          rdata_d        = bus.s_rdata;
          done_d[win_q]  = 1'b1;
          gnt_d          = '0;
          ptr_d          = ptr_next;
          cnt_d          = '0;
          state_d        = DONE;
        end else if (TIMEOUT != 0 && cnt_inc == (CNT_W+1)'(TIMEOUT)) begin
          rdata_d        = '0;
          done_d[win_q]  = 1'b1;
          err_d[win_q]   = 1'b1;
          gnt_d          = '0;
          ptr_d          = ptr_next;
          cnt_d          = '0;
          state_d        = DONE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      saddr_q  <= '0;
      smode_q  <= '0;
      swdata_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
      saddr_q  <= saddr_d;
      smode_q  <= smode_d;
      swdata_q <= swdata_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.m_gnt   = gnt_q;
  assign bus.m_done  = done_q;
  assign bus.m_err   = err_q;
  assign bus.m_rdata = rdata_q;
  assign bus.s_start = start_q;
  assign bus.s_addr  = saddr_q;
  assign bus.s_mode  = smode_q;
  assign bus.s_wdata = swdata_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_simple_bus_rr_arbiter.sv
// Bench for simple_bus_rr_arbiter: directed scenarios then random transactions,
// checked against a transaction-level round-robin model.
module tb_simple_bus_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simple_bus_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  simple_bus_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ptr   = 0;
  logic [DW-1:0] last_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++)
      if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_master(input int i, input logic [AW-1:0] a, input logic [1:0] m,
                            input logic [DW-1:0] d);
    bus.m_addr[i*AW +: AW]  = a;
    bus.m_mode[i*2 +: 2]    = m;
    bus.m_wdata[i*DW +: DW] = d;
  endtask

  // Call with the DUT idle and m_req already set; the next edge is the arbitration edge.
  // rdy_at = XFER cycle number in which s_rdy is raised (0 = never).
  task automatic run_txn(input int rdy_at, input logic [DW-1:0] rd, input bit drop_req,
                         input bit drop_mid, output int w);
    logic [AW-1:0] ea;
    logic [1:0]    em;
    logic [DW-1:0] ed;
    bit            done;
    bit            err;
    w  = pick(bus.m_req, ptr);
    if (w < 0) w = 0;
    ea = bus.m_addr[w*AW +: AW];
    em = bus.m_mode[w*2 +: 2];
    ed = bus.m_wdata[w*DW +: DW];
    @(posedge clk); #1;
    chk("gnt_start", bus.m_gnt, 32'(1) << w);
    chk("s_start", bus.s_start, 1);
    chk("s_addr", bus.s_addr, ea);
    chk("s_mode", bus.s_mode, em);
    chk("s_wdata", bus.s_wdata, ed);
    chk("busy_xfer", bus.busy, 1);
    if (drop_mid) bus.m_req[w] = 1'b0;
    done = 0;
    err  = 0;
    for (int c = 1; c <= TO + 2 && !done; c++) begin
      bus.s_rdy   = (c == rdy_at);
      bus.s_rdata = (c == rdy_at) ? rd : DW'($urandom);
      @(posedge clk); #1;
      if (c == rdy_at) done = 1;
      else if (c == TO) begin done = 1; err = 1; end
      if (done) begin
        chk("m_done", bus.m_done, 32'(1) << w);
        chk("m_err", bus.m_err, err ? (32'(1) << w) : 0);
        chk("m_rdata", bus.m_rdata, err ? 0 : rd);
        chk("gnt_drop", bus.m_gnt, 0);
        last_rdata = err ? '0 : rd;
      end else begin
        chk("gnt_hold", bus.m_gnt, 32'(1) << w);
        chk("start_low", bus.s_start, 0);
        chk("no_done", bus.m_done, 0);
      end
    end
    if (!done) chk("xfer_bound", 0, 1);
    ptr = (w + 1) % N;
    bus.s_rdy   = 1'($urandom);
    bus.s_rdata = DW'($urandom);
    if (drop_req) bus.m_req[w] = 1'b0;
    @(posedge clk); #1;
    chk("done_once", bus.m_done, 0);
    chk("err_once", bus.m_err, 0);
    chk("busy_idle", bus.busy, 0);
    chk("gnt_idle", bus.m_gnt, 0);
    chk("rdata_hold", bus.m_rdata, last_rdata);
    bus.s_rdy = 1'($urandom);
  endtask

  initial begin
    int w;
    int seq [5] = '{0, 1, 2, 3, 0};
    bus.m_req = '0; bus.m_addr = '0; bus.m_mode = '0; bus.m_wdata = '0;
    bus.s_rdy = 1'b0; bus.s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", bus.m_gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.s_start, 0);
    rst = 1'b0;

    // Single master 2, write to 0x3C, ready in third XFER cycle
    set_master(2, 8'h3C, 2'b01, 8'h77);
    bus.m_req = 4'b0100;
    run_txn(3, 8'h5E, 1, 0, w);
    chk("t1_win", w, 2);

    // Read from master 1 with ready in the s_start cycle
    set_master(1, 8'h12, 2'b00, 8'h00);
    bus.m_req = 4'b0010;
    run_txn(1, 8'hA5, 1, 0, w);
    chk("t3_win", w, 1);

    // Timeout with no ready
    set_master(0, 8'h40, 2'b10, 8'h99);
    bus.m_req = 4'b0001;
    run_txn(0, 8'hFF, 1, 0, w);

    // Ready coincides with the timeout cycle
    set_master(3, 8'hC3, 2'b11, 8'h3A);
    bus.m_req = 4'b1000;
    run_txn(TO, 8'h6B, 1, 0, w);

    // All requests held high: strict rotation
    bus.m_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_txn(1 + (i % 3), DW'($urandom), 0, 0, w);
      chk("rr_order", w, seq[i]);
    end

    // Reset in the middle of a transfer (pointer is at 1 here)
    bus.s_rdy = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_gnt", bus.m_gnt, 4'b0010);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.s_rdy = 1'b1;
    @(posedge clk); #1;
    chk("midrst_gnt", bus.m_gnt, 0);
    chk("midrst_done", bus.m_done, 0);
    chk("midrst_err", bus.m_err, 0);
    chk("midrst_rdata", bus.m_rdata, 0);
    chk("midrst_saddr", bus.s_addr, 0);
    chk("midrst_busy", bus.busy, 0);
    rst = 1'b0;
    bus.s_rdy = 1'b0;
    ptr = 0;
    last_rdata = '0;
    run_txn(2, 8'h3D, 0, 0, w);
    chk("post_rst_win", w, 0);

    // Random traffic, including mid-transfer request drops
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        set_master(i, AW'($urandom), 2'($urandom), DW'($urandom));
      bus.m_req = 4'($urandom_range(1, 15));
      run_txn($urandom_range(0, TO + 1), DW'($urandom), 1'($urandom), 1'($urandom), w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
